// File: rtl/l1_mem_responder_if.sv
// AXI bundle for the l1 responder (m_axi_l1 port seen from the memory side).
// master = task core / bench side, slave = l1_mem_responder.
interface l1_mem_responder_if;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic        BID;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] RDATA;
  logic        RLAST;
  logic        RID;
  logic [1:0]  RRESP;

  modport master (
    output AWVALID, AWADDR, AWLEN, AWSIZE, WVALID, WDATA, WSTRB, WLAST, BREADY,
           ARVALID, ARADDR, ARLEN, ARSIZE, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, BID, ARREADY, RVALID, RDATA, RLAST, RID, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWLEN, AWSIZE, WVALID, WDATA, WSTRB, WLAST, BREADY,
           ARVALID, ARADDR, ARLEN, ARSIZE, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, BID, ARREADY, RVALID, RDATA, RLAST, RID, RRESP
  );
endinterface

// File: rtl/l1_mem_responder.sv
// AXI responder serving INCR read bursts and single-beat strobed writes from a word array.
// Define L1_RESP_STALL_EN to add LFSR-driven ready/valid stalls.
module l1_mem_responder #(
  parameter int MEM_ADDR_BITS = 12,
  parameter int INIT_ZERO     = 1
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  l1_mem_responder_if.slave        s_axi_l1,
  input  logic                     init_we,
  input  logic [MEM_ADDR_BITS-1:0] init_addr,
  input  logic [31:0]              init_wdata
);
  localparam int unsigned DEPTH     = 1 << MEM_ADDR_BITS;
  localparam logic [32:0] LIMIT     = 33'(DEPTH) << 2;
  localparam logic [31:0] MEM_PWRUP = (INIT_ZERO != 0) ? '0 : 'x;

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_BURST = 1'b1;
  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_RESP  = 1'b1;

  // Power-up contents only; reset never touches the array.
  logic [31:0] r_mem [DEPTH] = '{default: MEM_PWRUP};

  logic        w_stall;
  logic [0:0]  r_rstate;
  logic [32:0] r_raddr;
  logic [7:0]  r_rcnt;
  logic        r_rvalid;
  logic        r_rlast;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        w_ar_hs;
  logic        w_r_hs;
  logic        w_rlast_next;
  logic [32:0] w_raddr_next;
  logic        w_roor;
  logic [31:0] w_rword;

  logic [0:0]  r_wstate;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        w_wready;
  logic        w_aw_acc;
  logic        w_wok;
  logic [MEM_ADDR_BITS-1:0] w_widx;
  logic        w_unused_size;

`ifdef L1_RESP_STALL_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge ap_clk) begin
    if (ap_rst) r_lfsr <= 16'hACE1;
    else        r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  end
  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  // Address of the beat fetched this cycle: AR address when idle, next word after a
  // handshake, or the already-advanced address while a stalled beat is pending.
  always_comb begin
    w_ar_hs      = (r_rstate == R_IDLE) && !w_stall && s_axi_l1.ARVALID;
    w_r_hs       = r_rvalid && s_axi_l1.RREADY;
    w_raddr_next = r_raddr;
    w_rlast_next = (r_rcnt == 8'd0);
    if (r_rstate == R_IDLE) begin
      w_raddr_next = {1'b0, s_axi_l1.ARADDR};
      w_rlast_next = (s_axi_l1.ARLEN == 8'd0);
    end else if (w_r_hs) begin
      w_raddr_next = r_raddr + 33'd4;
      w_rlast_next = (r_rcnt == 8'd1);
    end
    w_roor  = (w_raddr_next >= LIMIT);
    w_rword = w_roor ? '0 : r_mem[w_raddr_next[MEM_ADDR_BITS+1:2]];
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_rstate <= R_IDLE;
      r_raddr  <= '0;
      r_rcnt   <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else if (r_rstate == R_IDLE) begin
      if (w_ar_hs) begin
        r_rstate <= R_BURST;
        r_raddr  <= w_raddr_next;
        r_rcnt   <= s_axi_l1.ARLEN;
        r_rvalid <= 1'b1;
        r_rlast  <= w_rlast_next;
        r_rdata  <= w_rword;
        r_rresp  <= w_roor ? 2'b10 : 2'b00;
      end
    end else if (w_r_hs && r_rlast) begin
      r_rstate <= R_IDLE;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
    end else if (w_r_hs || !r_rvalid) begin
      if (w_r_hs) begin
        r_raddr <= w_raddr_next;
        r_rcnt  <= r_rcnt - 8'd1;
      end
      r_rvalid <= !w_stall;
      if (!w_stall) begin
        r_rlast <= w_rlast_next;
        r_rdata <= w_rword;
        r_rresp <= w_roor ? 2'b10 : 2'b00;
      end
    end
  end

  always_comb begin
    w_wready = (r_wstate == W_IDLE) && !init_we && !w_stall;
    w_aw_acc = w_wready && s_axi_l1.AWVALID && s_axi_l1.WVALID;
    w_wok    = (s_axi_l1.AWLEN == 8'd0) && s_axi_l1.WLAST && ({1'b0, s_axi_l1.AWADDR} < LIMIT);
    w_widx   = s_axi_l1.AWADDR[MEM_ADDR_BITS+1:2];
  end

  always_ff @(posedge ap_clk) begin
    if (init_we) begin
      r_mem[init_addr] <= init_wdata;
    end else if (w_aw_acc && w_wok) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (s_axi_l1.WSTRB[i]) r_mem[w_widx][8*i +: 8] <= s_axi_l1.WDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_wstate <= W_IDLE;
      r_bvalid <= 1'b0;
      r_bresp  <= '0;
    end else if (r_wstate == W_IDLE) begin
      if (w_aw_acc) begin
        r_wstate <= W_RESP;
        r_bvalid <= 1'b1;
        r_bresp  <= w_wok ? 2'b00 : 2'b10;
      end
    end else if (s_axi_l1.BREADY) begin
      r_wstate <= W_IDLE;
      r_bvalid <= 1'b0;
    end
  end

  assign w_unused_size = ^{s_axi_l1.ARSIZE, s_axi_l1.AWSIZE};

  assign s_axi_l1.ARREADY = (r_rstate == R_IDLE) && !w_stall;
  assign s_axi_l1.RVALID  = r_rvalid;
  assign s_axi_l1.RDATA   = r_rdata;
  assign s_axi_l1.RLAST   = r_rlast;
  assign s_axi_l1.RRESP   = r_rresp;
  assign s_axi_l1.RID     = 1'b0;
  assign s_axi_l1.AWREADY = w_wready;
  assign s_axi_l1.WREADY  = w_wready;
  assign s_axi_l1.BVALID  = r_bvalid;
  assign s_axi_l1.BRESP   = r_bresp;
  assign s_axi_l1.BID     = 1'b0;
endmodule

// File: tb/tb_l1_mem_responder.sv
// Bench for l1_mem_responder: word-array model + expected-beat queues, checked every handshake.
`timescale 1ns/1ps
module tb_l1_mem_responder;
  localparam int AB = 12;
  localparam longint unsigned LIMIT = 4 * (longint'(1) << AB);

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          init_we = 1'b0;
  logic [AB-1:0] init_addr = '0;
  logic [31:0]   init_wdata = '0;

  l1_mem_responder_if axi();

  l1_mem_responder #(.MEM_ADDR_BITS(AB), .INIT_ZERO(1)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .s_axi_l1   (axi.slave),
    .init_we    (init_we),
    .init_addr  (init_addr),
    .init_wdata (init_wdata)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  int          n_pass = 0;
  int          n_total = 0;
  int          n_beats = 0;
  beat_t       rq[$];
  logic [1:0]  bq[$];
  logic [31:0] mm [int];
  beat_t       cmp_e;
  logic [1:0]  cmp_b;
  logic [31:0] last_rdata = '0;
  logic [1:0]  last_rresp = '0;
  logic [1:0]  last_bresp = '0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic [1:0]  hold_r;
  logic        hold_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic fail_to(input string name);
    n_total++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  function automatic logic [31:0] m_rd(input longint unsigned a);
    int idx;
    idx = int'(a >> 2);
    if (a >= LIMIT) return '0;
    return mm.exists(idx) ? mm[idx] : '0;
  endfunction

  // Scoreboard: every R/B handshake against the model's expected queues.
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("r_hold_valid", 32'(axi.RVALID), 32'd1);
        chk("r_hold_data", axi.RDATA, hold_d);
        chk("r_hold_resp", 32'(axi.RRESP), 32'(hold_r));
        chk("r_hold_last", 32'(axi.RLAST), 32'(hold_l));
      end
      if (axi.RVALID && axi.RREADY) begin
        if (rq.size() == 0) begin
          n_total++;
          $display("FAIL r_unexpected: got beat 0x%08h expected none", axi.RDATA);
        end else begin
          cmp_e = rq.pop_front();
          chk("r_data", axi.RDATA, cmp_e.data);
          chk("r_resp", 32'(axi.RRESP), 32'(cmp_e.resp));
          chk("r_last", 32'(axi.RLAST), 32'(cmp_e.last));
          chk("r_id", 32'(axi.RID), 32'd0);
        end
        n_beats++;
        last_rdata = axi.RDATA;
        last_rresp = axi.RRESP;
      end
      hold_v = axi.RVALID && !axi.RREADY;
      hold_d = axi.RDATA;
      hold_r = axi.RRESP;
      hold_l = axi.RLAST;
      if (axi.BVALID && axi.BREADY) begin
        if (bq.size() == 0) begin
          n_total++;
          $display("FAIL b_unexpected: got bresp %0d expected none", axi.BRESP);
        end else begin
          cmp_b = bq.pop_front();
          chk("b_resp", 32'(axi.BRESP), 32'(cmp_b));
          chk("b_id", 32'(axi.BID), 32'd0);
        end
        last_bresp = axi.BRESP;
      end
    end
  end

  task automatic do_init(input int idx, input logic [31:0] data);
    @(posedge ap_clk); #1;
    init_we = 1'b1; init_addr = AB'(idx); init_wdata = data;
    @(negedge ap_clk);
    chk("init_blocks_wr_ready", 32'({axi.AWREADY, axi.WREADY}), 32'd0);
    @(posedge ap_clk); #1;
    init_we = 1'b0;
    mm[idx] = data;
  endtask

  task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len);
    bit ok;
    ok = 1'b0;
    @(posedge ap_clk); #1;
    axi.ARADDR = addr; axi.ARLEN = len; axi.ARVALID = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge ap_clk);
      if (axi.ARREADY) begin
        chk("r_idle_rvalid", 32'(axi.RVALID), 32'd0);
        ok = 1'b1;
        break;
      end
    end
    @(posedge ap_clk); #1;
    axi.ARVALID = 1'b0;
    if (!ok) begin
      fail_to("ar_accept");
      return;
    end
    for (int i = 0; i <= int'(len); i++) begin
      longint unsigned a;
      a = longint'(addr) + 4 * i;
      rq.push_back('{data: m_rd(a), resp: (a >= LIMIT) ? 2'b10 : 2'b00, last: (i == int'(len))});
    end
    @(negedge ap_clk);
    chk("r_latency", 32'(axi.RVALID), 32'd1);
  endtask

  task automatic r_wait_done(input string name);
    for (int c = 0; c < 600; c++) begin
      @(posedge ap_clk); #1;
      if (rq.size() == 0) return;
    end
    fail_to(name);
  endtask

  task automatic do_read1(input logic [31:0] addr, input logic [31:0] exp_d,
                          input logic [1:0] exp_r, input string name);
    ar_issue(addr, 8'd0);
    r_wait_done(name);
    chk(name, last_rdata, exp_d);
    chk({name, "_resp"}, 32'(last_rresp), 32'(exp_r));
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [7:0] len, input logic last, input bit bhold,
                          input logic [1:0] exp_b, input string name);
    bit ok;
    bit good;
    ok = 1'b0;
    @(posedge ap_clk); #1;
    axi.AWADDR = addr; axi.AWLEN = len; axi.AWVALID = 1'b1;
    axi.WDATA = data; axi.WSTRB = strb; axi.WLAST = last; axi.WVALID = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge ap_clk);
      if (axi.AWREADY && axi.WREADY) begin ok = 1'b1; break; end
    end
    @(posedge ap_clk); #1;
    axi.AWVALID = 1'b0; axi.WVALID = 1'b0;
    if (bhold) axi.BREADY = 1'b0;
    if (!ok) begin
      fail_to({name, "_accept"});
      return;
    end
    good = (len == 8'd0) && last && (longint'(addr) < LIMIT);
    if (good) begin
      logic [31:0] w;
      w = m_rd(longint'(addr));
      for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = data[8*i +: 8];
      mm[int'(addr >> 2)] = w;
    end
    bq.push_back(good ? 2'b00 : 2'b10);
    @(negedge ap_clk);
    chk("b_latency", 32'(axi.BVALID), 32'd1);
    if (bhold) begin
      @(negedge ap_clk);
      chk("b_hold_valid", 32'(axi.BVALID), 32'd1);
      chk("b_resp_blocks_aw", 32'(axi.AWREADY), 32'd0);
      axi.BREADY = 1'b1;
    end
    for (int c = 0; c < 50; c++) begin
      @(posedge ap_clk); #1;
      if (bq.size() == 0) begin
        chk(name, 32'(last_bresp), 32'(exp_b));
        return;
      end
    end
    fail_to(name);
  endtask

  initial begin
    int n0;
    bit hit;
    axi.AWVALID = 1'b0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = 3'd2;
    axi.WVALID = 1'b0; axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b1;
    axi.BREADY = 1'b1;
    axi.ARVALID = 1'b0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = 3'd2;
    axi.RREADY = 1'b1;

    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_arready", 32'(axi.ARREADY), 32'd1);
    chk("rst_aw_w_ready", 32'({axi.AWREADY, axi.WREADY}), 32'd3);
    chk("rst_r_outputs", {28'd0, axi.RVALID, axi.RLAST, axi.RRESP}, 32'd0);
    chk("rst_rdata", axi.RDATA, 32'd0);
    chk("rst_b_outputs", 32'({axi.BVALID, axi.BRESP}), 32'd0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;

    do_init(3, 32'h100);
    do_init(4, 32'h200);
    do_init(5, 32'h300);
    do_read1(32'd12, 32'h100, 2'b00, "rd_w3");
    do_read1(32'd16, 32'h200, 2'b00, "rd_w4");
    do_read1(32'd20, 32'h300, 2'b00, "rd_w5");

    do_init(12'h400, 32'd7);
    do_init(12'h401, 32'd11);
    n0 = n_beats;
    ar_issue(32'h1000, 8'd1);
    r_wait_done("burst2");
    chk("burst2_beats", 32'(n_beats - n0), 32'd2);
    chk("burst2_lastdata", last_rdata, 32'd11);

    do_init(12'h402, 32'h13);
    do_init(12'h403, 32'h17);
    n0 = n_beats;
    ar_issue(32'h1000, 8'd3);
    @(posedge ap_clk); #1;
    axi.RREADY = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1 axi.RREADY = 1'b1;
    r_wait_done("burst4_hold");
    chk("burst4_beats", 32'(n_beats - n0), 32'd4);
    chk("burst4_lastdata", last_rdata, 32'h17);

    do_init(5, 32'hAABBCCDD);
    do_write(32'd20, 32'h11223344, 4'b0101, 8'd0, 1'b1, 1'b1, 2'b00, "wr_strb");
    do_read1(32'd20, 32'hAA22CC44, 2'b00, "rd_strb");

    do_init(4095, 32'hCAFEF00D);
    ar_issue(32'(LIMIT - 4), 8'd1);
    r_wait_done("boundary");
    chk("boundary_beat2", last_rdata, 32'd0);
    chk("boundary_resp2", 32'(last_rresp), 32'd2);

    do_write(32'd20, 32'hFFFFFFFF, 4'hF, 8'd1, 1'b1, 1'b0, 2'b10, "wr_awlen1");
    do_write(32'd20, 32'hFFFFFFFF, 4'hF, 8'd0, 1'b0, 1'b0, 2'b10, "wr_nolast");
    do_write(32'(LIMIT), 32'hFFFFFFFF, 4'hF, 8'd0, 1'b1, 1'b0, 2'b10, "wr_oor");
    do_read1(32'd20, 32'hAA22CC44, 2'b00, "rd_unchanged");

    @(posedge ap_clk); #1;
    axi.AWADDR = 32'd24; axi.AWLEN = '0; axi.AWVALID = 1'b1;
    repeat (3) @(negedge ap_clk);
    chk("aw_alone_no_b", 32'(axi.BVALID), 32'd0);
    axi.AWVALID = 1'b0; axi.WVALID = 1'b1; axi.WLAST = 1'b1; axi.WSTRB = 4'hF;
    repeat (3) @(negedge ap_clk);
    chk("w_alone_no_b", 32'(axi.BVALID), 32'd0);
    axi.WVALID = 1'b0;
    do_read1(32'd24, 32'd0, 2'b00, "rd_no_partial_write");

    n0 = n_beats;
    ar_issue(32'd0, 8'd255);
    r_wait_done("burst256");
    chk("burst256_beats", 32'(n_beats - n0), 32'd256);

    for (int i = 0; i < 8; i++) do_init(12'h500 + i, 32'h5000 + 32'(i));
    n0 = n_beats;
    hit = 1'b0;
    ar_issue(32'h1400, 8'd7);
    for (int c = 0; c < 100; c++) begin
      @(posedge ap_clk); #1;
      if (n_beats - n0 >= 3) begin hit = 1'b1; break; end
    end
    if (!hit) fail_to("rst_mid_burst");
    ap_rst = 1'b1;
    rq.delete();
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("rst_mid_rvalid", 32'(axi.RVALID), 32'd0);
    chk("rst_mid_arready", 32'(axi.ARREADY), 32'd1);
    chk("rst_mid_rlast", 32'(axi.RLAST), 32'd0);
    do_read1(32'h1404, 32'h5001, 2'b00, "rd_after_rst");

    repeat (3) @(posedge ap_clk);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("bq_drained", 32'(bq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/l1_mem_responder.md
Name: l1_mem_responder

Overview:
- AXI responder (slave) for the 32-bit m_axi_l1 port that task cores drive as initiator.
- Serves single-beat and INCR burst reads, plus single-beat writes with byte strobes, from an on-chip word array.
- Used for standalone core bring-up and for unit benches of the des/sssp cores, without the L1 cache and tile fabric.
- A backdoor init port preloads graph/gate data before the core is started.

Parameters:
- MEM_ADDR_BITS, 12, log2 of array depth in 32-bit words; valid byte range is [0, 4*2^MEM_ADDR_BITS).
- INIT_ZERO, 1, if 1 the array powers up all-zero (initial block); reset never clears the array.

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous, active-high reset
- s_axi_l1_AWVALID in 1 / AWREADY out 1 / AWADDR in 32 / AWLEN in 8 / AWSIZE in 3  write address channel
- s_axi_l1_WVALID in 1 / WREADY out 1 / WDATA in 32 / WSTRB in 4 / WLAST in 1  write data channel
- s_axi_l1_BVALID out 1 / BREADY in 1 / BRESP out 2 / BID out 1  write response channel
- s_axi_l1_ARVALID in 1 / ARREADY out 1 / ARADDR in 32 / ARLEN in 8 / ARSIZE in 3  read address channel
- s_axi_l1_RVALID out 1 / RREADY in 1 / RDATA out 32 / RLAST out 1 / RID out 1 / RRESP out 2  read data channel
- init_we  in  1  backdoor word write strobe
- init_addr  in  MEM_ADDR_BITS  backdoor word index
- init_wdata  in  32  backdoor data

Behaviour:
- Reset values:
  - ARREADY=1, AWREADY=1, WREADY=1.
  - RVALID=0, RLAST=0, RDATA=0, RRESP=0.
  - BVALID=0, BRESP=0.
  - RID=BID=0 always.
- Word index = addr[MEM_ADDR_BITS+1:2]; addr[1:0] ignored. ARSIZE/AWSIZE ignored; 32-bit beats are required.
- Out of range: address >= 4*2^MEM_ADDR_BITS. Such a beat returns RDATA=0, RRESP=2'b10 (SLVERR); otherwise RRESP=2'b00.
- Read FSM R_IDLE / R_BURST:
  - R_IDLE: ARREADY=1. AR handshake at cycle T latches addr, sets beat counter = ARLEN, registers the first beat's data, and moves to R_BURST.
  - RVALID=1 at T+1. Read latency is exactly 1 cycle.
  - R_BURST: RVALID held high, RDATA/RLAST/RRESP held stable until RREADY.
  - On handshake of a non-last beat: address += 4 and the next beat is presented the following cycle (back-to-back, 1 beat/cycle under continuous RREADY).
  - RLAST=1 on beat ARLEN+1; ARLEN=255 gives 256 beats, so the counter must not wrap early.
  - A beat whose incremented address crosses the top of the array is SLVERR; there is no wrap-around.
  - After the last-beat handshake, return to R_IDLE. The earliest next AR accept is the following cycle; one read is outstanding at a time.
- Write FSM W_IDLE / W_RESP:
  - W_IDLE: AWREADY=WREADY=~init_we. Accept only when AWVALID & WVALID are both high in the same cycle; AW alone or W alone is not accepted.
  - On accept: byte lanes with WSTRB[i]=1 update the addressed word.
  - If AWLEN!=0 or WLAST=0, or the address is out of range: no array write, BRESP=2'b10. Otherwise BRESP=2'b00.
  - Move to W_RESP: BVALID=1 from the cycle after accept, held until BREADY, then back to W_IDLE. AWREADY=WREADY=0 in W_RESP.
- Same-cycle collisions:
  - Read-beat fetch and write to the same word: the read returns the old data (read-first). The write is visible to any beat fetched a later cycle.
  - init_we has priority over the AXI write port, so AWREADY/WREADY drop in that cycle.
  - init_we does not stall reads; a same-cycle read of the same word returns old data.
- Read and write FSMs are independent and may be active simultaneously.
- Reset mid-operation:
  - A burst or pending B is abandoned and all outputs return to their reset values next cycle.
  - Array contents are preserved. A write already accepted stays committed.

Optional Feature:
- Macro L1_RESP_STALL_EN.
- When defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 16'hACE1 on reset, advances every cycle. When lfsr[0]=1 that cycle:
  - ARREADY, AWREADY and WREADY are forced 0.
  - A pending next read beat is not presented; RVALID stays 0 between beats.
  - RVALID/BVALID, once asserted, are never dropped.
- When undefined: no LFSR logic; behaviour is exactly as above with no stalls.

Test Plan:
- Init words 3,4,5 = 0x100,0x200,0x300; ARADDR=12,16,20 with ARLEN=0 -> RDATA 0x100/0x200/0x300, each RVALID one cycle after AR accept, RLAST=1, RRESP=0.
- Init words 0x400,0x401 = 7,11; ARADDR=0x1000, ARLEN=1, RREADY=1 -> two consecutive beats 7 then 11, RLAST only on the second.
- Burst ARLEN=3 with RREADY low for 3 cycles at beat 2 -> beat 2 RDATA/RLAST held stable, no beat lost; 4 beats total.
- Word 5 = 0xAABBCCDD; write WDATA=0x11223344, WSTRB=4'b0101 -> BVALID next cycle, BRESP=0; readback 0xAA22CC44.
- ARADDR=4*2^MEM_ADDR_BITS-4, ARLEN=1 -> beat 1 valid data RRESP=0, beat 2 RDATA=0 RRESP=2'b10. Write with AWLEN=1 -> BRESP=2'b10, array unchanged.
- ap_rst asserted mid 8-beat burst after beat 3 -> RVALID=0 next cycle, ARREADY=1; a new ARLEN=0 read returns pre-reset array data.
